pc_ras: RTL and testbench



---
 rtl/pc_ras.sv | 109 ++++++++++
 tb/tb_pc_ras.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pc_ras.sv
// Program counter with stride increment, relative branch and a circular return-address stack.
// Build option: define PC_BRANCH_EN to enable the signed-offset branch on `br`.
module pc_ras #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int STEP  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in,
  input  logic                       ld,
  input  logic                       incr,
  input  logic                       br,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] ras_level,
  output logic                       ras_full,
  output logic                       ras_empty,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic [PW-1:0]    top_idx;

  // ptr_q points at the next slot to write; the top entry sits one below it.
  assign top_idx   = ptr_q - PW'(1);
  assign ras_full  = (lvl_q == FULL_LVL);
  assign ras_empty = (lvl_q == '0);

  always_comb begin
    pc_d      = pc_q;
    ptr_d     = ptr_q;
    lvl_d     = lvl_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_wdata = pc_q + STEP_W;
    if (ret) begin
      if (ras_empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d  = mem_q[top_idx];
        ptr_d = top_idx;
        lvl_d = lvl_q - LW'(1);
      end
    end else if (call) begin
      // When full the write lands on the oldest entry, since the pointer has wrapped onto it.
      mem_we = 1'b1;
      ptr_d  = ptr_q + PW'(1);
      pc_d   = in;
      if (ras_full) ovf_d = 1'b1;
      else          lvl_d = lvl_q + LW'(1);
    end else if (ld) begin
      pc_d = in;
`ifdef PC_BRANCH_EN
    end else if (br) begin
      pc_d = pc_q + in;
    end else if (incr) begin
      pc_d = pc_q + STEP_W;
    end
`else
    end else if (incr) begin
      pc_d = pc_q + STEP_W;
    end else if (br) begin
      pc_d = pc_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      ptr_q <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[ptr_q] <= mem_wdata;
  end

  assign out       = pc_q;
  assign ras_level = lvl_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras (WIDTH=16, DEPTH=8, STEP=1): vector table plus stack corner sequences.
module tb_pc_ras;

  logic        clk = 1'b0;
  logic        rst, ld, incr, br, call, ret;
  logic [15:0] in;
  logic [15:0] out;
  logic [3:0]  ras_level;
  logic        ras_full, ras_empty, ras_ovf, ras_unf;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst, ld, incr, br, call, ret;
    logic [15:0] in;
    logic [15:0] e_out;
    int          e_lvl;
    logic        e_ovf, e_unf;
  } vec_t;

  vec_t tbl[$];

  pc_ras #(.WIDTH(16), .DEPTH(8), .STEP(1)) dut (
    .clk(clk), .rst(rst), .in(in), .ld(ld), .incr(incr), .br(br),
    .call(call), .ret(ret), .out(out), .ras_level(ras_level),
    .ras_full(ras_full), .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  // command string: r=rst l=ld i=incr b=br c=call t=ret
  function automatic vec_t mk(input string cmd, input logic [15:0] din,
                              input logic [15:0] e_out, input int e_lvl,
                              input logic e_ovf, input logic e_unf);
    vec_t v;
    v.rst = 0; v.ld = 0; v.incr = 0; v.br = 0; v.call = 0; v.ret = 0;
    for (int k = 0; k < cmd.len(); k++) begin
      case (cmd[k])
        "r": v.rst  = 1;
        "l": v.ld   = 1;
        "i": v.incr = 1;
        "b": v.br   = 1;
        "c": v.call = 1;
        "t": v.ret  = 1;
        default: ;
      endcase
    end
    v.in = din; v.e_out = e_out; v.e_lvl = e_lvl; v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic check(input string name, input vec_t v);
    logic e_full, e_empty;
    e_full  = (v.e_lvl == 8);
    e_empty = (v.e_lvl == 0);
    n_checks++;
    if (out !== v.e_out || ras_level !== 4'(v.e_lvl) || ras_full !== e_full ||
        ras_empty !== e_empty || ras_ovf !== v.e_ovf || ras_unf !== v.e_unf) begin
      n_fail++;
      $display("FAIL %s: got out=%h lvl=%0d full=%b empty=%b ovf=%b unf=%b, want out=%h lvl=%0d full=%b empty=%b ovf=%b unf=%b",
               name, out, ras_level, ras_full, ras_empty, ras_ovf, ras_unf,
               v.e_out, v.e_lvl, e_full, e_empty, v.e_ovf, v.e_unf);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    @(negedge clk);
    rst = v.rst; ld = v.ld; incr = v.incr; br = v.br; call = v.call; ret = v.ret; in = v.in;
    @(posedge clk);
    #1;
    check(name, v);
  endtask

  logic [15:0] br1, br2, br3;

  initial begin
    rst = 1; ld = 0; incr = 0; br = 0; call = 0; ret = 0; in = '0;
`ifdef PC_BRANCH_EN
    br1 = 16'h0030; br2 = 16'h0035; br3 = 16'h003A;
`else
    br1 = 16'h0040; br2 = 16'h0040; br3 = 16'h0041;
`endif
    tbl.push_back(mk("r",  16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk("i",  16'h0000, 16'h0001, 0, 0, 0));
    tbl.push_back(mk("i",  16'h0000, 16'h0002, 0, 0, 0));
    tbl.push_back(mk("i",  16'h0000, 16'h0003, 0, 0, 0));
    tbl.push_back(mk("",   16'h5555, 16'h0003, 0, 0, 0));
    tbl.push_back(mk("l",  16'hFFFF, 16'hFFFF, 0, 0, 0));
    tbl.push_back(mk("i",  16'h0000, 16'h0000, 0, 0, 0));
    tbl.push_back(mk("li", 16'h1234, 16'h1234, 0, 0, 0));
    tbl.push_back(mk("tl", 16'h5678, 16'h1234, 0, 0, 1));
    tbl.push_back(mk("l",  16'h0010, 16'h0010, 0, 0, 1));
    tbl.push_back(mk("c",  16'h0100, 16'h0100, 1, 0, 1));
    tbl.push_back(mk("cl", 16'h0200, 16'h0200, 2, 0, 1));
    tbl.push_back(mk("tci",16'h0999, 16'h0101, 1, 0, 1));
    tbl.push_back(mk("t",  16'h0000, 16'h0011, 0, 0, 1));
    tbl.push_back(mk("l",  16'h0040, 16'h0040, 0, 0, 1));
    tbl.push_back(mk("b",  16'hFFF0, br1,      0, 0, 1));
    tbl.push_back(mk("b",  16'h0005, br2,      0, 0, 1));
    tbl.push_back(mk("bi", 16'h0005, br3,      0, 0, 1));
    tbl.push_back(mk("l",  16'hFFFF, 16'hFFFF, 0, 0, 1));
    tbl.push_back(mk("c",  16'h0020, 16'h0020, 1, 0, 1));
    tbl.push_back(mk("t",  16'h0000, 16'h0000, 0, 0, 1));
    tbl.push_back(mk("rtc",16'h0300, 16'h0000, 0, 0, 0));

    @(posedge clk); #1;
    check("reset_initial", mk("r", 16'h0000, 16'h0000, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // Overflow: 9 nested calls from 0x10..0x18 push 0x11..0x19; 0x11 is overwritten.
    step("ovf_ld", mk("l", 16'h0010, 16'h0010, 0, 0, 0));
    for (int i = 0; i < 9; i++) begin
      logic [15:0] tgt;
      tgt = 16'h0011 + 16'(i);
      step($sformatf("ovf_call%0d", i),
           mk("c", tgt, tgt, (i < 8) ? i + 1 : 8, (i == 8), 0));
    end
    for (int i = 0; i < 8; i++) begin
      step($sformatf("ovf_ret%0d", i),
           mk("t", 16'h0000, 16'h0019 - 16'(i), 7 - i, 1, 0));
    end

    // Reset mid-operation with the overflow flag still set.
    step("mid_call0", mk("c", 16'h0100, 16'h0100, 1, 1, 0));
    step("mid_call1", mk("c", 16'h0200, 16'h0200, 2, 1, 0));
    step("mid_call2", mk("c", 16'h0300, 16'h0300, 3, 1, 0));
    step("mid_rst_ret", mk("rt", 16'h0000, 16'h0000, 0, 0, 0));
    step("post_rst_ret", mk("t", 16'h0000, 16'h0000, 0, 0, 1));
    step("hold", mk("", 16'hABCD, 16'h0000, 0, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
